// File: rtl/serdes_link_check_ctrl_pkg.sv
// Shared types and widths for the SERDES link-check sequencer.
package serdes_ctrl_pkg;

    localparam int unsigned TIMER_W   = 24;
    localparam int unsigned ERR_ACC_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHK_RST = 3'd1,
        ACQUIRE = 3'd2,
        MONITOR = 3'd3,
        GT_RST  = 3'd4
    } state_e;

    // Adds an 8-bit delta to the error accumulator, pinning at all-ones.
    function automatic logic [ERR_ACC_W-1:0] sat_add(input logic [ERR_ACC_W-1:0] a,
                                                     input logic [7:0]           d);
        logic [ERR_ACC_W:0] s;
        s = {1'b0, a} + {{(ERR_ACC_W - 7){1'b0}}, d};
        return s[ERR_ACC_W] ? '1 : s[ERR_ACC_W-1:0];
    endfunction

endpackage

// File: rtl/serdes_link_check_ctrl_if.sv
// Control/status bundle between the link-check sequencer and its environment.
interface serdes_link_check_ctrl_if;
    import serdes_ctrl_pkg::*;

    logic                 GT_RESET_DONE_IN;
    logic                 TRACK_DATA_IN;
    logic [7:0]           ERROR_COUNT_IN;
    logic                 CHECKER_RESET_OUT;
    logic                 GT_RX_RESET_OUT;
    logic                 LINK_UP_OUT;
    logic [3:0]           RETRY_COUNT_OUT;
    logic [ERR_ACC_W-1:0] WINDOW_ERRORS_OUT;
    logic [2:0]           STATE_OUT;

    modport master (
        output GT_RESET_DONE_IN, TRACK_DATA_IN, ERROR_COUNT_IN,
        input  CHECKER_RESET_OUT, GT_RX_RESET_OUT, LINK_UP_OUT,
               RETRY_COUNT_OUT, WINDOW_ERRORS_OUT, STATE_OUT
    );

    modport slave (
        input  GT_RESET_DONE_IN, TRACK_DATA_IN, ERROR_COUNT_IN,
        output CHECKER_RESET_OUT, GT_RX_RESET_OUT, LINK_UP_OUT,
               RETRY_COUNT_OUT, WINDOW_ERRORS_OUT, STATE_OUT
    );

endinterface

// File: rtl/serdes_link_check_ctrl_err_window_acc.sv
// Turns the checker's wrapping error count into per-window totals.
module serdes_err_window_acc
    import serdes_ctrl_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic                 window_end_i,
    input  logic [7:0]           count_i,
    output logic [ERR_ACC_W-1:0] acc_o,
    output logic [ERR_ACC_W-1:0] window_total_o
);

    logic [7:0]           prev_q;
    logic [7:0]           delta;
    logic [ERR_ACC_W-1:0] acc_q;
    logic [ERR_ACC_W-1:0] acc_d;
    logic [ERR_ACC_W-1:0] total_q;

    // Unsigned 8-bit subtraction gives the modulo-256 increment across count wraps.
    assign delta = count_i - prev_q;
    assign acc_d = sat_add(acc_q, delta);

    // acc_o already includes this cycle's delta so window-end decisions see the full total.
    assign acc_o          = acc_d;
    assign window_total_o = total_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q  <= '0;
            acc_q   <= '0;
            total_q <= '0;
        end else if (clear_i) begin
            prev_q <= count_i;
            acc_q  <= '0;
        end else if (enable_i) begin
            prev_q <= count_i;
            if (window_end_i) begin
                total_q <= acc_d;
                acc_q   <= '0;
            end else begin
                acc_q <= acc_d;
            end
        end
    end

endmodule

// File: rtl/serdes_link_check_ctrl.sv
// Per-lane frame-checker sequencer: reset, acquire, windowed error monitor, retry/escalate.
module serdes_link_check_ctrl
    import serdes_ctrl_pkg::*;
#(
    parameter int unsigned CHK_RST_CYCLES = 16,
    parameter int unsigned ACQ_TIMEOUT    = 4096,
    parameter int unsigned WINDOW_CYCLES  = 65536,
    parameter int unsigned ERR_THRESHOLD  = 0,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned GT_RST_CYCLES  = 32
) (
    input logic                     USER_CLK,
    input logic                     SYSTEM_RESET,
    serdes_link_check_ctrl_if.slave bus
);

    if (CHK_RST_CYCLES == 0 || CHK_RST_CYCLES >= 2**TIMER_W ||
        ACQ_TIMEOUT    == 0 || ACQ_TIMEOUT    >= 2**TIMER_W ||
        WINDOW_CYCLES  == 0 || WINDOW_CYCLES  >= 2**TIMER_W ||
        GT_RST_CYCLES  == 0 || GT_RST_CYCLES  >= 2**TIMER_W ||
        ERR_THRESHOLD  >= 2**TIMER_W || MAX_RETRIES > 15) begin : g_bad_param
        $error("serdes_link_check_ctrl: parameter out of range");
    end

    localparam logic [TIMER_W-1:0] CHK_LAST  = TIMER_W'(CHK_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ACQ_LAST  = TIMER_W'(ACQ_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] WIN_LAST  = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GT_LAST   = TIMER_W'(GT_RST_CYCLES - 1);
    localparam logic [3:0]         RETRY_MAX = 4'(MAX_RETRIES);

    state_e               state_q;
    logic [TIMER_W-1:0]   timer_q;
    logic                 chk_rst_q;
    logic                 gt_rst_q;
    logic                 link_up_q;
    logic [3:0]           retry_q;

    logic                 acc_clear;
    logic                 acc_en;
    logic                 win_end;
    logic                 win_fail;
    logic                 fail;
    logic [ERR_ACC_W-1:0] win_acc;

    assign acc_clear = (state_q == ACQUIRE) && bus.TRACK_DATA_IN;
    assign acc_en    = (state_q == MONITOR);
    assign win_end   = acc_en && (timer_q == WIN_LAST);
    assign win_fail  = win_end && (32'(win_acc) > ERR_THRESHOLD);

    // Track loss coinciding with a failing window end folds into this single flag.
    assign fail = ((state_q == ACQUIRE) && !bus.TRACK_DATA_IN && (timer_q == ACQ_LAST)) ||
                  ((state_q == MONITOR) && (!bus.TRACK_DATA_IN || win_fail));

    serdes_err_window_acc u_acc (
        .clk_i          (USER_CLK),
        .rst_i          (SYSTEM_RESET),
        .clear_i        (acc_clear),
        .enable_i       (acc_en),
        .window_end_i   (win_end),
        .count_i        (bus.ERROR_COUNT_IN),
        .acc_o          (win_acc),
        .window_total_o (bus.WINDOW_ERRORS_OUT)
    );

    always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            chk_rst_q <= 1'b1;
            gt_rst_q  <= 1'b0;
            link_up_q <= 1'b0;
            retry_q   <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
            case (state_q)
                IDLE: begin
                    chk_rst_q <= 1'b1;
                    timer_q   <= '0;
                    if (bus.GT_RESET_DONE_IN) begin
                        state_q <= CHK_RST;
                    end
                end
                CHK_RST, ACQUIRE, MONITOR: begin
                    if (!bus.GT_RESET_DONE_IN) begin
                        state_q   <= IDLE;
                        chk_rst_q <= 1'b1;
                        link_up_q <= 1'b0;
                        timer_q   <= '0;
                    end else if (fail) begin
                        chk_rst_q <= 1'b1;
                        link_up_q <= 1'b0;
                        timer_q   <= '0;
                        if (retry_q < RETRY_MAX) begin
                            retry_q <= retry_q + 1'b1;
                            state_q <= CHK_RST;
                        end else begin
                            retry_q  <= '0;
                            gt_rst_q <= 1'b1;
                            state_q  <= GT_RST;
                        end
                    end else begin
                        case (state_q)
                            CHK_RST: begin
                                if (timer_q == CHK_LAST) begin
                                    state_q   <= ACQUIRE;
                                    chk_rst_q <= 1'b0;
                                    timer_q   <= '0;
                                end
                            end
                            ACQUIRE: begin
                                if (bus.TRACK_DATA_IN) begin
                                    state_q <= MONITOR;
                                    timer_q <= '0;
                                end
                            end
                            MONITOR: begin
                                if (win_end) begin
                                    link_up_q <= 1'b1;
                                    retry_q   <= '0;
                                    timer_q   <= '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                GT_RST: begin
                    if (timer_q == GT_LAST) begin
                        state_q  <= IDLE;
                        gt_rst_q <= 1'b0;
                        timer_q  <= '0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    chk_rst_q <= 1'b1;
                    gt_rst_q  <= 1'b0;
                    link_up_q <= 1'b0;
                    timer_q   <= '0;
                end
            endcase
        end
    end

    assign bus.CHECKER_RESET_OUT = chk_rst_q;
    assign bus.GT_RX_RESET_OUT   = gt_rst_q;
    assign bus.LINK_UP_OUT       = link_up_q;
    assign bus.RETRY_COUNT_OUT   = retry_q;
    assign bus.STATE_OUT         = state_q;

endmodule

// File: tb/tb_serdes_link_check_ctrl.sv
// Directed bench for serdes_link_check_ctrl with a queued expected-value scoreboard.
module tb_serdes_link_check_ctrl;
    import serdes_ctrl_pkg::*;

    localparam int unsigned CHK = 4;
    localparam int unsigned ACQ = 20;
    localparam int unsigned WIN = 100;
    localparam int unsigned THR = 2;
    localparam int unsigned RET = 3;
    localparam int unsigned GTC = 32;

    logic clk = 1'b0;
    logic rst;

    serdes_link_check_ctrl_if bus();

    serdes_link_check_ctrl #(
        .CHK_RST_CYCLES (CHK),
        .ACQ_TIMEOUT    (ACQ),
        .WINDOW_CYCLES  (WIN),
        .ERR_THRESHOLD  (THR),
        .MAX_RETRIES    (RET),
        .GT_RST_CYCLES  (GTC)
    ) dut (
        .USER_CLK     (clk),
        .SYSTEM_RESET (rst),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_v(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_underflow observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Counts clock cycles spent in state s (current sample must already be s).
    task automatic dwell(input logic [2:0] s, output int n);
        n = 0;
        while (bus.STATE_OUT == s && n < 1000) begin
            tick;
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.GT_RESET_DONE_IN = 1'b0;
        bus.TRACK_DATA_IN    = 1'b0;
        bus.ERROR_COUNT_IN   = 8'd0;

        expect_v("rst_state", 0);
        expect_v("rst_chk", 1);
        expect_v("rst_gt", 0);
        expect_v("rst_link", 0);
        expect_v("rst_retry", 0);
        expect_v("rst_werr", 0);
        repeat (3) tick;
        check_v(32'(bus.STATE_OUT));
        check_v(32'(bus.CHECKER_RESET_OUT));
        check_v(32'(bus.GT_RX_RESET_OUT));
        check_v(32'(bus.LINK_UP_OUT));
        check_v(32'(bus.RETRY_COUNT_OUT));
        check_v(32'(bus.WINDOW_ERRORS_OUT));
        rst = 1'b0;
        tick;

        expect_v("idle_hold", 0);
        repeat (5) tick;
        check_v(32'(bus.STATE_OUT));

        // Bring-up with a constant error count
        bus.GT_RESET_DONE_IN = 1'b1;
        expect_v("bring_chk_state", 1);
        tick;
        check_v(32'(bus.STATE_OUT));
        expect_v("bring_chk_len", CHK);
        dwell(3'd1, n);
        check_v(32'(n));
        expect_v("bring_acq_state", 2);
        expect_v("bring_chk_low", 0);
        check_v(32'(bus.STATE_OUT));
        check_v(32'(bus.CHECKER_RESET_OUT));
        repeat (10) tick;
        bus.TRACK_DATA_IN = 1'b1;
        expect_v("bring_mon_state", 3);
        tick;
        check_v(32'(bus.STATE_OUT));
        expect_v("bring_link_early", 0);
        repeat (WIN - 1) tick;
        check_v(32'(bus.LINK_UP_OUT));
        expect_v("bring_link_up", 1);
        expect_v("bring_werr", 0);
        expect_v("bring_retry", 0);
        tick;
        check_v(32'(bus.LINK_UP_OUT));
        check_v(32'(bus.WINDOW_ERRORS_OUT));
        check_v(32'(bus.RETRY_COUNT_OUT));

        // Three errors in one window exceed the threshold of two
        for (int i = 1; i <= 3; i++) begin
            bus.ERROR_COUNT_IN = 8'(i);
            tick;
        end
        expect_v("errwin_link_hold", 1);
        repeat (WIN - 4) tick;
        check_v(32'(bus.LINK_UP_OUT));
        expect_v("errwin_werr", 3);
        expect_v("errwin_link", 0);
        expect_v("errwin_retry", 1);
        expect_v("errwin_state", 1);
        tick;
        check_v(32'(bus.WINDOW_ERRORS_OUT));
        check_v(32'(bus.LINK_UP_OUT));
        check_v(32'(bus.RETRY_COUNT_OUT));
        check_v(32'(bus.STATE_OUT));

        // Error count wraps 254 -> 255 -> 0 -> 1 inside a window
        bus.ERROR_COUNT_IN = 8'd254;
        expect_v("retry_chk_len", CHK);
        dwell(3'd1, n);
        check_v(32'(n));
        expect_v("wrap_mon_state", 3);
        tick;
        check_v(32'(bus.STATE_OUT));
        bus.ERROR_COUNT_IN = 8'd255;
        tick;
        bus.ERROR_COUNT_IN = 8'd0;
        tick;
        bus.ERROR_COUNT_IN = 8'd1;
        tick;
        repeat (WIN - 4) tick;
        expect_v("wrap_werr", 3);
        expect_v("wrap_retry", 2);
        tick;
        check_v(32'(bus.WINDOW_ERRORS_OUT));
        check_v(32'(bus.RETRY_COUNT_OUT));

        // A clean window clears the retry count
        dwell(3'd1, n);
        tick;
        repeat (WIN) tick;
        expect_v("clean_link", 1);
        expect_v("clean_retry", 0);
        expect_v("clean_werr", 0);
        check_v(32'(bus.LINK_UP_OUT));
        check_v(32'(bus.RETRY_COUNT_OUT));
        check_v(32'(bus.WINDOW_ERRORS_OUT));

        // One-cycle track loss in MONITOR
        bus.TRACK_DATA_IN = 1'b0;
        expect_v("tl_state", 1);
        expect_v("tl_link", 0);
        expect_v("tl_retry", 1);
        expect_v("tl_chk", 1);
        tick;
        check_v(32'(bus.STATE_OUT));
        check_v(32'(bus.LINK_UP_OUT));
        check_v(32'(bus.RETRY_COUNT_OUT));
        check_v(32'(bus.CHECKER_RESET_OUT));
        bus.TRACK_DATA_IN = 1'b1;
        dwell(3'd1, n);
        expect_v("tl_remon", 3);
        tick;
        check_v(32'(bus.STATE_OUT));
        repeat (5) tick;

        // GT reset-done loss in MONITOR
        bus.GT_RESET_DONE_IN = 1'b0;
        expect_v("gd_state", 0);
        expect_v("gd_retry", 1);
        expect_v("gd_link", 0);
        expect_v("gd_chk", 1);
        tick;
        check_v(32'(bus.STATE_OUT));
        check_v(32'(bus.RETRY_COUNT_OUT));
        check_v(32'(bus.LINK_UP_OUT));
        check_v(32'(bus.CHECKER_RESET_OUT));
        expect_v("gd_idle_hold", 0);
        repeat (3) tick;
        check_v(32'(bus.STATE_OUT));

        // SYSTEM_RESET mid-ACQUIRE, checked without a clock edge
        bus.GT_RESET_DONE_IN = 1'b1;
        bus.TRACK_DATA_IN    = 1'b0;
        tick;
        dwell(3'd1, n);
        repeat (3) tick;
        expect_v("sr_pre_state", 2);
        check_v(32'(bus.STATE_OUT));
        rst = 1'b1;
        #1;
        expect_v("sr_state", 0);
        expect_v("sr_chk", 1);
        expect_v("sr_retry", 0);
        check_v(32'(bus.STATE_OUT));
        check_v(32'(bus.CHECKER_RESET_OUT));
        check_v(32'(bus.RETRY_COUNT_OUT));
        tick;
        rst = 1'b0;

        // Acquire timeouts: three retries then GT RX reset escalation
        tick;
        for (int r = 1; r <= 3; r++) begin
            expect_v("esc_chk_len", CHK);
            dwell(3'd1, n);
            check_v(32'(n));
            expect_v("esc_acq_len", ACQ);
            dwell(3'd2, n);
            check_v(32'(n));
            expect_v("esc_retry", 32'(r));
            expect_v("esc_state", 1);
            check_v(32'(bus.RETRY_COUNT_OUT));
            check_v(32'(bus.STATE_OUT));
        end
        dwell(3'd1, n);
        expect_v("esc4_acq_len", ACQ);
        dwell(3'd2, n);
        check_v(32'(n));
        expect_v("gtr_state", 4);
        expect_v("gtr_gt", 1);
        expect_v("gtr_chk", 1);
        expect_v("gtr_retry", 0);
        check_v(32'(bus.STATE_OUT));
        check_v(32'(bus.GT_RX_RESET_OUT));
        check_v(32'(bus.CHECKER_RESET_OUT));
        check_v(32'(bus.RETRY_COUNT_OUT));
        bus.GT_RESET_DONE_IN = 1'b0;
        expect_v("gtr_len", GTC);
        dwell(3'd4, n);
        check_v(32'(n));
        expect_v("gtr_end_state", 0);
        expect_v("gtr_end_gt", 0);
        check_v(32'(bus.STATE_OUT));
        check_v(32'(bus.GT_RX_RESET_OUT));
        expect_v("post_gt_idle", 0);
        repeat (2) tick;
        check_v(32'(bus.STATE_OUT));
        bus.GT_RESET_DONE_IN = 1'b1;
        expect_v("post_gt_restart", 1);
        tick;
        check_v(32'(bus.STATE_OUT));

        checks++;
        assert (sb.size() === 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
